// File: rtl/length_writer.sv
// Per-lane row-length FIFOs reassembled in row order and packed
// four lengths per word for the length memory.
module length_writer #(
    parameter int LANES  = 4,
    parameter int LEN_W  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        write,
    input  logic [31:0]       in,
    output logic [3:0]        full,
    input  logic              flush,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  fifo [LANES][DEPTH];
    logic [PW-1:0]     wptr [LANES];
    logic [PW-1:0]     rptr [LANES];
    logic [CW-1:0]     count [LANES];
    logic [1:0]        cur;
    logic [31:0]       pack;
    logic [ADDR_W-1:0] addr;

    logic [LANES-1:0]  push;
    logic [LANES-1:0]  nonempty;
    logic [LANES-1:0]  pop_lane;
    logic              pop;
    logic              all_empty;
    logic [LEN_W-1:0]  head;

    always_comb begin
        full     = '0;
        push     = '0;
        nonempty = '0;
        pop_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            full[i]     = (count[i] == CW'(DEPTH));
            push[i]     = write[i] && !full[i];
            nonempty[i] = (count[i] != '0);
        end
        pop       = nonempty[cur];
        all_empty = ~|nonempty;
        head      = fifo[cur][rptr[cur]];
        for (int i = 0; i < LANES; i++)
            pop_lane[i] = pop && (cur == 2'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cur      <= '0;
            pack     <= '0;
            addr     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            done     <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (push[i]) begin
                    fifo[i][wptr[i]] <= in[i*LEN_W +: LEN_W];
                    wptr[i]          <= wptr[i] + 1'b1;
                end
                if (pop_lane[i])
                    rptr[i] <= rptr[i] + 1'b1;
                count[i] <= count[i] + CW'(push[i])
                          - CW'(pop_lane[i]);
            end
            // byte 3 completes a word; pack is cleared so flushes stay zero-padded
            if (pop) begin
                if (cur == 2'd3) begin
                    mem_we   <= 1'b1;
                    mem_addr <= addr;
                    mem_data <= {head, pack[23:0]};
                    addr     <= addr + 1'b1;
                    pack     <= '0;
                end else begin
                    pack[cur*LEN_W +: LEN_W] <= head;
                end
                cur <= cur + 1'b1;
            end
            unique case (state)
                RUN: begin
                    if (flush)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (all_empty) begin
                        if (cur != 2'd0) begin
                            mem_we   <= 1'b1;
                            mem_addr <= addr;
                            mem_data <= pack;
                            addr     <= addr + 1'b1;
                        end
                        done  <= 1'b1;
                        cur   <= '0;
                        pack  <= '0;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_length_writer.sv
// Scoreboard bench for length_writer: expected words queued at
// stimulus time, compared as mem_we pulses appear.
module tb_length_writer;

    logic        clk;
    logic        rst;
    logic [3:0]  write;
    logic [31:0] in;
    logic [3:0]  full;
    logic        flush;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        done;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t       sbq [$];
    logic [9:0] exp_addr;
    logic       done_ok;
    int         n_checks;
    int         n_fail;

    length_writer dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .in       (in),
        .full     (full),
        .flush    (flush),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mem_we) begin
                if (sbq.size() == 0) begin
                    check("unexpected_we", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                    check("mem_data", mem_data, e.data);
                end
            end
            if (done)
                check("done_expected", 32'(done_ok), 32'd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] w, input logic [31:0] d);
        write = w;
        in    = d;
        @(negedge clk);
        write = '0;
        in    = '0;
    endtask

    task automatic expect_word(input logic [31:0] d);
        sbq.push_back('{exp_addr, d});
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 60 && sbq.size() != 0; i++)
            @(negedge clk);
        cyc(1);
        check("sb_drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_addr = '0;
        done_ok  = 1'b0;
        rst      = 1'b1;
        write    = '0;
        in       = '0;
        flush    = 1'b0;
        cyc(3);
        rst = 1'b0;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", mem_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_full", 32'(full), 32'd0);

        // full row, latency, then two back-to-back rows
        expect_word(32'h04030201);
        drive(4'hF, 32'h04030201);
        cyc(3);
        check("lat_early", 32'(mem_we), 32'd0);
        cyc(1);
        check("lat_we", 32'(mem_we), 32'd1);
        wait_sb();
        expect_word(32'h08070605);
        expect_word(32'h0C0B0A09);
        drive(4'hF, 32'h08070605);
        drive(4'hF, 32'h0C0B0A09);
        wait_sb();

        // out-of-order arrival
        drive(4'h8, 32'h44000000);
        cyc(5);
        drive(4'h4, 32'h00330000);
        cyc(5);
        drive(4'h2, 32'h00002200);
        cyc(5);
        check("ooo_hold", 32'(mem_we), 32'd0);
        expect_word(32'h44332211);
        drive(4'h1, 32'h00000011);
        wait_sb();

        // overflow: prime lane 0 so cur moves off it
        drive(4'h1, 32'h000000EE);
        cyc(2);
        for (int v = 1; v <= 4; v++)
            drive(4'h1, 32'(v));
        check("full_after_4", 32'(full), 32'h1);
        drive(4'h1, 32'd5);
        check("full_hold", 32'(full), 32'h1);
        for (int j = 0; j < 5; j++) begin
            logic [7:0] b0;
            logic [7:0] b1;
            logic [7:0] b2;
            logic [7:0] b3;
            b0 = (j == 0) ? 8'hEE : 8'(j);
            b1 = 8'(8'h10 + j);
            b2 = 8'(8'h20 + j);
            b3 = 8'(8'h30 + j);
            expect_word({b3, b2, b1, b0});
            drive(4'hE, {b3, b2, b1, 8'h00});
            cyc(6);
        end
        wait_sb();
        check("ovf_full_clr", 32'(full), 32'd0);

        // partial flush
        expect_word(32'h0000BBAA);
        done_ok = 1'b1;
        drive(4'h3, 32'h0000BBAA);
        cyc(3);
        pulse_flush();
        wait_done();
        check("pflush_we", 32'(mem_we), 32'd1);
        check("pflush_data", mem_data, 32'h0000BBAA);
        cyc(1);
        done_ok = 1'b0;
        wait_sb();
        expect_word(32'h44332211);
        drive(4'hF, 32'h44332211);
        wait_sb();

        // empty flush
        done_ok = 1'b1;
        pulse_flush();
        wait_done();
        check("eflush_we", 32'(mem_we), 32'd0);
        cyc(1);
        done_ok = 1'b0;
        cyc(2);

        // reset with lanes 0-2 holding data
        drive(4'h7, 32'h00332211);
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mrst_we", 32'(mem_we), 32'd0);
        check("mrst_addr", 32'(mem_addr), 32'd0);
        check("mrst_data", mem_data, 32'd0);
        check("mrst_full", 32'(full), 32'd0);
        exp_addr = '0;
        expect_word(32'hDDCCBBAA);
        drive(4'hF, 32'hDDCCBBAA);
        wait_sb();
        cyc(8);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
